seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS common-anode digits. Per digit, it drives the 4-bit BCD code into the decoder and selects that digit's anode.
- Double-buffers the displayed value, so a new value is never shown mid-frame.
- Inserts an all-anodes-off blanking gap between digits to prevent ghosting.
- Blanks leading zeros and invalid codes (>9), because the decoder's output is undefined for those codes.
Sits between the counter datapath and the segment decoder.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=1).
DWELL_CYCLES, 50000, clk cycles each digit's anode is asserted (>=1).
BLANK_CYCLES, 500, clk cycles with all anodes off before each digit (>=0; 0 removes the gap).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  1 = scan; 0 = display dark
load  in  1  single-cycle strobe; capture digits_in into pending buffer
digits_in  in  4*NUM_DIGITS  BCD digits; [3:0] = digit 0 (rightmost)
lz_blank_en  in  1  1 = suppress leading zeros
load_ack  out  1  1-cycle pulse, the cycle after load is sampled
bcd_out  out  4  BCD code to shared decoder
seg_blank  out  1  1 = force decoder segments off (gated downstream)
an  out  NUM_DIGITS  anode selects, active-low
frame_done  out  1  1-cycle pulse after last digit's dwell

Behaviour:
Interface:
- Single clock, clk.
- Reset rst is synchronous and active-high.
- All outputs are registered.

Reset values:
- an = all 1s; bcd_out = 0; seg_blank = 1; load_ack = 0; frame_done = 0.
- Active and pending buffers = 0; pending_valid = 0; idx = 0; state = IDLE.
- Reset asserted mid-frame takes effect on the next edge, regardless of state.

States: IDLE, BLANK, DRIVE.
- IDLE: an = all 1s, seg_blank = 1.
  - If enable = 1: transfer pending to active if pending_valid, set idx = 0, go to BLANK (or straight to DRIVE if BLANK_CYCLES = 0).
- BLANK: an = all 1s; lasts exactly BLANK_CYCLES cycles.
  - On entry, bcd_out and seg_blank are updated for digit idx, so the decoder settles before the anode turns on.
- DRIVE: an[idx] = 0, other anodes 1; lasts exactly DWELL_CYCLES cycles.
  - Last cycle with idx < NUM_DIGITS-1: idx++, go to BLANK/DRIVE.
  - Last cycle with idx = NUM_DIGITS-1: frame_done pulses on the next cycle, idx wraps to 0, pending transfers to active if pending_valid (pending_valid then clears), and the next frame starts.

Enable deassertion:
- enable = 0 in any state: next cycle go to IDLE, an = all 1s, seg_blank = 1, idx = 0.
- Pending buffer is retained. No frame_done is issued for the aborted frame.

Load handling:
- load = 1: pending <= digits_in, pending_valid <= 1, load_ack = 1 next cycle.
- Back-to-back loads: the last one wins.
- load in the same cycle as a frame-boundary transfer: the old pending goes to active, the new value goes to pending, and pending_valid stays 1.

Blanking rules for digit i (evaluated on the active buffer):
- Invalid code (value > 9): seg_blank = 1 and bcd_out = 0. The anode still cycles, so timing is unchanged.
- Leading zero: when lz_blank_en = 1, i != 0, and digits i..NUM_DIGITS-1 are all 0, seg_blank = 1. Digit 0 is never zero-blanked.
- Otherwise seg_blank = 0 and bcd_out = digit i.

Timing:
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Counter widths are $clog2 of the respective maxima, minimum 1 bit.
- Counters saturate/reload only at phase ends and never wrap mid-phase.

Decomposition:
- seg_scan_pkg holds:
  - state enum (IDLE, BLANK, DRIVE);
  - BCD_W = 4 and BCD_MAX = 9;
  - a function returning the leading-zero blank mask for a digit vector.
- One sub-module, scan_phase_timer: a loadable down-counter with a terminal-count pulse, reused for both BLANK and DWELL. Everything else lives in seg_scan_ctrl.

Test Plan:
Bench parameters: NUM_DIGITS = 4, DWELL_CYCLES = 4, BLANK_CYCLES = 1.
1. Reset, then enable = 1, load digits_in = 0x4321:
   - load_ack pulses once.
   - Anode sequence (an): 1111, then 1110 for 4 cycles with bcd_out = 1, then 1111, then 1101 with bcd_out = 2, then digit 2 = 3, then digit 3 = 4.
   - frame_done pulses once every 20 cycles.
2. Mid-frame load of 0x9999 while driving digit 1:
   - Digits 1–3 of the current frame still show 2, 3, 4.
   - The next frame shows 9 on all digits.
3. lz_blank_en = 1, value 0x0050:
   - seg_blank = 1 for digits 3 and 2.
   - seg_blank = 0 for digit 1 (5) and digit 0 (0).
   - With value 0x0000, only digit 0 is unblanked.
4. Invalid value 0x00A7:
   - Digit 1 has seg_blank = 1 and bcd_out = 0, with an[1] still asserted for 4 cycles.
   - Digit 0 shows 7 normally.
5. enable dropped during DRIVE of digit 2:
   - Next cycle an = 1111, seg_blank = 1, no frame_done.
   - On re-enable, the scan restarts at digit 0.
6. rst asserted during DRIVE of digit 1:
   - Next cycle all outputs are at reset values, and the active buffer is cleared to 0.
   - Simultaneous load + frame-boundary case: both values appear in order on consecutive frames.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam int BCD_W      = 4;
    localparam int BCD_MAX    = 9;
    // Widest digit vector the leading-zero helper accepts.
    localparam int MAX_DIGITS = 16;

    // Bit i set when digit i and every more-significant digit are zero.
    // Digit 0 is never flagged, so a value of zero still shows one "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [BCD_W*MAX_DIGITS-1:0] digits,
        input int                          num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  zero_run;
        mask     = '0;
        zero_run = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < num_digits) begin
                zero_run = zero_run && (digits[i*BCD_W +: BCD_W] == '0);
                mask[i]  = zero_run;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/scan_phase_timer.sv
// Loadable down-counter that flags the last cycle of a BLANK or DRIVE phase.
// Latency: tc is high in the cycle the count reaches zero; a load of N-1 gives an N-cycle phase.
// Backpressure: none; the count holds at zero until reloaded, never wrapping.
module scan_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Count down from the loaded value and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexes one BCD-to-7-segment decoder across NUM_DIGITS common-anode digits.
// Latency: outputs are registered; a digit's code is presented at the start of its blanking gap.
// Backpressure: none; loads are always accepted, the newest pending value wins at a frame boundary.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          load,
    input  logic [BCD_W*NUM_DIGITS-1:0]   digits_in,
    input  logic                          lz_blank_en,
    output logic                          load_ack,
    output logic [BCD_W-1:0]              bcd_out,
    output logic                          seg_blank,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_done
);

    localparam int DIG_W  = BCD_W * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int T_MAX  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TMR_W-1:0] DWELL_LD = TMR_W'(DWELL_CYCLES - 1);
    localparam logic [TMR_W-1:0] BLANK_LD = TMR_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    // With no gap configured, each digit begins directly in DRIVE.
    localparam state_t FIRST_PHASE = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

    state_t                  state, next_state;
    logic [IDX_W-1:0]        idx, next_idx;
    logic                    tc, timer_load;
    logic [TMR_W-1:0]        timer_val;
    logic [DIG_W-1:0]        active, pending, act_next;
    logic                    pending_valid;
    logic                    frame_end, digit_start, xfer;

    logic [BCD_W*MAX_DIGITS-1:0] act_wide;
    logic [NUM_DIGITS-1:0]       lz;
    logic [BCD_W-1:0]            cur_dig;
    logic [NUM_DIGITS-1:0]       an_d;
    logic [BCD_W-1:0]            bcd_d;
    logic                        seg_blank_d;

    // Phase boundaries: a digit starts on leaving IDLE or at the end of the previous dwell.
    assign frame_end   = enable && (state == DRIVE) && tc && (idx == LAST_IDX);
    assign digit_start = enable && ((state == IDLE) || ((state == DRIVE) && tc));
    assign xfer        = pending_valid && ((enable && (state == IDLE)) || frame_end);
    assign timer_load  = enable && ((state == IDLE) || tc);
    assign timer_val   = (next_state == BLANK) ? BLANK_LD : DWELL_LD;
    assign act_next    = xfer ? pending : active;

    scan_phase_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (tc)
    );

    // State and digit index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    // Next state: enable low always parks in IDLE; otherwise step phases on terminal count.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        if (!enable) begin
            next_state = IDLE;
            next_idx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    next_state = FIRST_PHASE;
                    next_idx   = '0;
                end
                BLANK: begin
                    if (tc) next_state = DRIVE;
                end
                DRIVE: begin
                    if (tc) begin
                        next_state = FIRST_PHASE;
                        next_idx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_idx   = '0;
                end
            endcase
        end
    end

    // Next outputs: anode follows the next phase; digit code is refreshed only at digit start.
    always_comb begin
        act_wide               = '0;
        act_wide[DIG_W-1:0]    = act_next;
        lz                     = NUM_DIGITS'(lz_mask(act_wide, NUM_DIGITS));
        cur_dig                = act_next[next_idx*BCD_W +: BCD_W];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = !((next_state == DRIVE) && (next_idx == IDX_W'(i)));
        end
        bcd_d       = bcd_out;
        seg_blank_d = seg_blank;
        if (next_state == IDLE) begin
            bcd_d       = '0;
            seg_blank_d = 1'b1;
        end else if (digit_start) begin
            if (cur_dig > BCD_W'(BCD_MAX)) begin
                // The decoder output is undefined above 9, so never present such a code.
                bcd_d       = '0;
                seg_blank_d = 1'b1;
            end else begin
                bcd_d       = cur_dig;
                seg_blank_d = lz_blank_en && lz[next_idx];
            end
        end
    end

    // Display buffers: transfer takes the old pending value before a same-cycle load replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            if (xfer) begin
                active        <= pending;
                pending_valid <= 1'b0;
            end
            if (load) begin
                pending       <= digits_in;
                pending_valid <= 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= '1;
            bcd_out    <= '0;
            seg_blank  <= 1'b1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            an         <= an_d;
            bcd_out    <= bcd_d;
            seg_blank  <= seg_blank_d;
            load_ack   <= load;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a frame-position reference model.
// Latency: model predicts the registered outputs visible after each rising edge.
// Backpressure: n/a.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int DW    = 4;
    localparam int BL    = 1;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = N * SLOT;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           load = 1'b0;
    logic [4*N-1:0] digits_in = '0;
    logic           lz_blank_en = 1'b0;
    logic           load_ack;
    logic [3:0]     bcd_out;
    logic           seg_blank;
    logic [N-1:0]   an;
    logic           frame_done;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .DWELL_CYCLES (DW),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load        (load),
        .digits_in   (digits_in),
        .lz_blank_en (lz_blank_en),
        .load_ack    (load_ack),
        .bcd_out     (bcd_out),
        .seg_blank   (seg_blank),
        .an          (an),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: scan position within the frame plus the two display buffers.
    bit         armed = 1'b0;
    bit         running = 1'b0;
    int         pos = 0;
    logic [3:0] m_act [N];
    logic [3:0] m_pend [N];
    bit         m_pv = 1'b0;
    bit         m_xf;
    int         m_slot, m_off;
    bit         m_zero;
    logic [N-1:0] e_an = '1;
    logic [3:0] e_bcd = '0;
    logic       e_sb = 1'b1, e_ack = 1'b0, e_fd = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model update on every rising edge, from the inputs sampled at that edge.
    always @(posedge clk) begin
        if (rst) begin
            armed   = 1'b1;
            running = 1'b0;
            pos     = 0;
            m_pv    = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_act[i]  = 4'd0;
                m_pend[i] = 4'd0;
            end
            e_an = '1; e_bcd = 4'd0; e_sb = 1'b1; e_ack = 1'b0; e_fd = 1'b0;
        end else begin
            m_xf  = 1'b0;
            e_ack = load;
            e_fd  = 1'b0;
            if (!enable) begin
                running = 1'b0;
                e_an = '1; e_bcd = 4'd0; e_sb = 1'b1;
            end else begin
                if (!running) begin
                    running = 1'b1;
                    pos     = 0;
                    m_xf    = 1'b1;
                end else begin
                    pos++;
                    if (pos == FRAME) begin
                        pos  = 0;
                        e_fd = 1'b1;
                        m_xf = 1'b1;
                    end
                end
                if (m_xf && m_pv) begin
                    m_act = m_pend;
                    m_pv  = 1'b0;
                end
            end
            if (load) begin
                for (int i = 0; i < N; i++) m_pend[i] = digits_in[4*i +: 4];
                m_pv = 1'b1;
            end
            if (running) begin
                m_slot = pos / SLOT;
                m_off  = pos % SLOT;
                e_an   = '1;
                if (m_off >= BL) e_an[m_slot] = 1'b0;
                if (m_off == 0) begin
                    m_zero = 1'b1;
                    for (int i = m_slot; i < N; i++) if (m_act[i] != 0) m_zero = 1'b0;
                    if (m_act[m_slot] > 9) begin
                        e_bcd = 4'd0; e_sb = 1'b1;
                    end else begin
                        e_bcd = m_act[m_slot];
                        e_sb  = lz_blank_en && (m_slot != 0) && m_zero;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            cmp("an", an, e_an);
            cmp("bcd_out", bcd_out, e_bcd);
            cmp("seg_blank", seg_blank, e_sb);
            cmp("load_ack", load_ack, e_ack);
            cmp("frame_done", frame_done, e_fd);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until the model sits at frame position p (bounded).
    task automatic run_to(input int p);
        int n;
        n = 0;
        while (!(running && pos == p)) begin
            tick();
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL run_to: position %0d not reached within 200 cycles", p);
                break;
            end
        end
    endtask

    task automatic do_load(input logic [4*N-1:0] v);
        digits_in = v;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        cmp("rst_an", an, 32'hF);
        cmp("rst_bcd", bcd_out, 32'h0);
        cmp("rst_blank", seg_blank, 32'h1);
        cmp("rst_ack", load_ack, 32'h0);
        cmp("rst_fd", frame_done, 32'h0);
        rst = 1'b0;

        // Basic scan of 4321.
        do_load(16'h4321);
        cmp("t1_ack_pulse", load_ack, 32'h1);
        tick();
        cmp("t1_ack_clear", load_ack, 32'h0);
        enable = 1'b1;
        tick();
        cmp("t1_gap0_an", an, 32'hF);
        cmp("t1_gap0_bcd", bcd_out, 32'h1);
        tick();
        cmp("t1_d0_an", an, 32'hE);
        cmp("t1_d0_bcd", bcd_out, 32'h1);
        cmp("t1_d0_blank", seg_blank, 32'h0);
        repeat (3) tick();
        cmp("t1_d0_last_an", an, 32'hE);
        tick();
        cmp("t1_gap1_an", an, 32'hF);
        cmp("t1_gap1_bcd", bcd_out, 32'h2);
        tick();
        cmp("t1_d1_an", an, 32'hD);
        run_to(11);
        cmp("t1_d2_an", an, 32'hB);
        cmp("t1_d2_bcd", bcd_out, 32'h3);
        run_to(16);
        cmp("t1_d3_an", an, 32'h7);
        cmp("t1_d3_bcd", bcd_out, 32'h4);
        run_to(0);
        cmp("t1_fd_pulse", frame_done, 32'h1);
        tick();
        cmp("t1_fd_clear", frame_done, 32'h0);

        // Mid-frame load while digit 1 is driven.
        run_to(7);
        do_load(16'h9999);
        run_to(13);
        cmp("t2_cur_d2", bcd_out, 32'h3);
        run_to(18);
        cmp("t2_cur_d3", bcd_out, 32'h4);
        run_to(3);
        cmp("t2_new_d0", bcd_out, 32'h9);
        run_to(13);
        cmp("t2_new_d2", bcd_out, 32'h9);

        // Leading-zero suppression.
        lz_blank_en = 1'b1;
        do_load(16'h0050);
        run_to(0);
        run_to(3);
        cmp("t3_d0_blank", seg_blank, 32'h0);
        cmp("t3_d0_bcd", bcd_out, 32'h0);
        run_to(8);
        cmp("t3_d1_blank", seg_blank, 32'h0);
        cmp("t3_d1_bcd", bcd_out, 32'h5);
        run_to(13);
        cmp("t3_d2_blank", seg_blank, 32'h1);
        run_to(18);
        cmp("t3_d3_blank", seg_blank, 32'h1);
        cmp("t3_d3_an", an, 32'h7);
        do_load(16'h0000);
        run_to(3);
        cmp("t3z_d0_blank", seg_blank, 32'h0);
        run_to(8);
        cmp("t3z_d1_blank", seg_blank, 32'h1);
        run_to(18);
        cmp("t3z_d3_blank", seg_blank, 32'h1);

        // Invalid code on digit 1.
        lz_blank_en = 1'b0;
        do_load(16'h00A7);
        run_to(3);
        cmp("t4_d0_bcd", bcd_out, 32'h7);
        cmp("t4_d0_blank", seg_blank, 32'h0);
        run_to(6);
        cmp("t4_d1_an", an, 32'hD);
        cmp("t4_d1_blank", seg_blank, 32'h1);
        cmp("t4_d1_bcd", bcd_out, 32'h0);
        run_to(9);
        cmp("t4_d1_last_an", an, 32'hD);
        run_to(10);
        cmp("t4_gap2_an", an, 32'hF);

        // Enable dropped while digit 2 is driven.
        run_to(12);
        enable = 1'b0;
        tick();
        cmp("t5_off_an", an, 32'hF);
        cmp("t5_off_blank", seg_blank, 32'h1);
        cmp("t5_off_fd", frame_done, 32'h0);
        repeat (2) tick();
        enable = 1'b1;
        tick();
        cmp("t5_re_gap_an", an, 32'hF);
        cmp("t5_re_bcd", bcd_out, 32'h7);
        tick();
        cmp("t5_re_d0_an", an, 32'hE);

        // Reset during digit 1 drive.
        run_to(7);
        rst = 1'b1;
        tick();
        cmp("t6_rst_an", an, 32'hF);
        cmp("t6_rst_bcd", bcd_out, 32'h0);
        cmp("t6_rst_blank", seg_blank, 32'h1);
        cmp("t6_rst_fd", frame_done, 32'h0);
        rst = 1'b0;
        tick();
        run_to(8);
        cmp("t6_cleared_bcd", bcd_out, 32'h0);
        cmp("t6_cleared_blank", seg_blank, 32'h0);

        // Load coinciding with a frame-boundary transfer.
        run_to(5);
        do_load(16'h1111);
        run_to(19);
        do_load(16'h2222);
        run_to(3);
        cmp("t7_first_d0", bcd_out, 32'h1);
        run_to(18);
        cmp("t7_first_d3", bcd_out, 32'h1);
        run_to(3);
        cmp("t7_second_d0", bcd_out, 32'h2);
        run_to(18);
        cmp("t7_second_d3", bcd_out, 32'h2);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            load = ($urandom_range(0, 7) == 0);
            if (load) begin
                for (int k = 0; k < N; k++) digits_in[4*k +: 4] = 4'($urandom_range(0, 11));
                if ($urandom_range(0, 2) == 0) digits_in[15:8] = '0;
            end
            if ($urandom_range(0, 99) == 0) enable = !enable;
            if ($urandom_range(0, 199) == 0) lz_blank_en = !lz_blank_en;
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst  = 1'b0;
        load = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
